// File: rtl/iq_pkg.sv
// Shared constants for the IQ path: the CORDIC arctangent table, the discriminator
// FSM state type and the CORDIC gain-compensation constant.
package iq_pkg;

  localparam int ATAN_MAX_PW = 16;
  localparam int ATAN_W      = ATAN_MAX_PW + 3;
  localparam int ATAN_KW     = $clog2(ATAN_MAX_PW);

  // atan(2^-k) in units of 2^-ATAN_W turn (one turn = 2^19), rounded.
  localparam logic [ATAN_W-1:0] ATAN_TAB [ATAN_MAX_PW] = '{
    19'd65536, 19'd38688, 19'd20442, 19'd10377,
    19'd5208,  19'd2607,  19'd1304,  19'd652,
    19'd326,   19'd163,   19'd81,    19'd41,
    19'd20,    19'd10,    19'd5,     19'd3
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ITER,
    ST_POST,
    ST_DONE
  } state_t;

  // 1/K = 0.607253 as an unsigned Q0.16 fraction.
  localparam int          GAIN_COMP_FRAC = 16;
  localparam logic [15:0] GAIN_COMP      = 16'd39797;

  // Table entry k rescaled (with rounding) to a phase width of pw+3 bits.
  function automatic logic [ATAN_W-1:0] atan_entry(input logic [ATAN_KW-1:0] k,
                                                   input int pw);
    logic [ATAN_W:0] v;
    int              sh;
    sh = ATAN_MAX_PW - pw;
    v  = {1'b0, ATAN_TAB[k]};
    if (sh > 0) v = (v + ((ATAN_W+1)'(1) << (sh - 1))) >> sh;
    return v[ATAN_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_vector_stage.sv
// One combinational CORDIC vectoring micro-rotation; the discriminator FSM feeds
// it back on itself once per iteration.
module cordic_vector_stage #(
  parameter int XW = 19,
  parameter int ZW = 15,
  parameter int KW = 4
) (
  input  logic signed [XW-1:0] i_x,
  input  logic signed [XW-1:0] i_y,
  input  logic        [ZW-1:0] i_z,
  input  logic        [ZW-1:0] i_atan,
  input  logic        [KW-1:0] i_k,
  input  logic                 i_neg,
  output logic signed [XW-1:0] o_x,
  output logic signed [XW-1:0] o_y,
  output logic        [ZW-1:0] o_z
);

  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;

  // Rotate toward the +x axis: y>=0 turns clockwise and adds the angle.
  always_comb begin
    w_xs = i_x >>> i_k;
    w_ys = i_y >>> i_k;
    if (i_neg) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - i_atan;
    end else begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + i_atan;
    end
  end

endmodule

// File: rtl/iq_freq_discriminator.sv
// Iterative CORDIC phase recovery plus phase-step / DDS-increment discriminator.
// Define IQDISC_GAIN_COMP_EN to add a POST state that scales the magnitude by 1/K.
module iq_freq_discriminator
  import iq_pkg::*;
#(
  parameter int PW = 12,
  parameter int IW = 17,
  parameter int AW = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_valid,
  input  logic signed [IW-1:0] i_sample_i,
  input  logic signed [IW-1:0] i_sample_q,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic        [PW-1:0] o_phase,
  output logic signed [PW-1:0] o_dphase,
  output logic        [AW-2:0] o_increment,
  output logic          [IW:0] o_magnitude
);

  localparam int XW = IW + 2;
  localparam int ZW = PW + 3;
  localparam int KW = $clog2(PW);
  localparam logic [KW-1:0] K_LAST = KW'(PW - 1);

  state_t               r_state, w_next;
  logic signed [XW-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic        [ZW-1:0] r_z, w_z_nxt, w_atan, w_z_rnd;
  logic        [KW-1:0] r_k;
  logic                 r_zero, r_valid, r_prev_valid;
  logic        [PW-1:0] r_phase, r_dphase, r_prev_phase, w_phase, w_dphase;
  logic        [AW-2:0] r_increment, w_increment;
  logic          [IW:0] r_mag, w_mag;
  logic                 w_accept;

  assign w_accept = i_ce && i_valid && o_ready;

  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   r_state <= ST_IDLE;
    else if (i_ce) r_state <= w_next;
  end

  // NOTE: w_next gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_PRE;
      ST_PRE:  w_next = ST_ITER;
`ifdef IQDISC_GAIN_COMP_EN
      ST_ITER: if (r_k == K_LAST) w_next = ST_POST;
`else
      ST_ITER: if (r_k == K_LAST) w_next = ST_DONE;
`endif
      ST_POST: w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Ready stays low during the result strobe; the strobe waits for an enabled cycle.
  always_comb begin
    o_ready = (r_state == ST_IDLE) && !r_valid;
    o_valid = r_valid && i_ce;
  end

  assign w_atan = ZW'(atan_entry(ATAN_KW'(r_k), PW));

  cordic_vector_stage #(.XW(XW), .ZW(ZW), .KW(KW)) u_stage (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_atan (w_atan),
    .i_k    (r_k),
    .i_neg  (r_y[XW-1]),
    .o_x    (w_x_nxt),
    .o_y    (w_y_nxt),
    .o_z    (w_z_nxt)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_k    <= '0;
      r_zero <= 1'b0;
    end else if (i_ce) begin
      unique case (r_state)
        ST_IDLE: if (w_accept) begin
          r_x    <= XW'(i_sample_i);
          r_y    <= XW'(i_sample_q);
          r_zero <= (i_sample_i == '0) && (i_sample_q == '0);
        end
        ST_PRE: begin
          r_k <= '0;
          if (r_x[XW-1]) begin
            r_x <= -r_x;
            r_y <= -r_y;
            r_z <= ZW'(1) << (ZW - 1);   // half a turn
          end else begin
            r_z <= '0;
          end
        end
        ST_ITER: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          r_k <= r_k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign w_z_rnd     = r_z + ZW'(4);
  assign w_phase     = r_zero ? '0 : w_z_rnd[ZW-1:3];
  assign w_dphase    = r_prev_valid ? (w_phase - r_prev_phase) : '0;
  assign w_increment = w_dphase[PW-1] ? '0 : ((AW-1)'(w_dphase) << (AW - 1 - PW));

`ifdef IQDISC_GAIN_COMP_EN
  logic [IW:0]    r_mag_comp;
  logic [IW+16:0] w_prod;
  assign w_mag  = r_mag_comp;
  assign w_prod = (IW+17)'(r_x[XW-1] ? '0 : r_x[XW-2:0]) * (IW+17)'(GAIN_COMP);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                            r_mag_comp <= '0;
    else if (i_ce && r_state == ST_POST)    r_mag_comp <= w_prod[IW+GAIN_COMP_FRAC:GAIN_COMP_FRAC];
  end
`else
  // x is never negative after pre-rotation; clamping covers the sign bit.
  assign w_mag = r_x[XW-1] ? '0 : r_x[XW-2:0];
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid      <= 1'b0;
      r_phase      <= '0;
      r_dphase     <= '0;
      r_increment  <= '0;
      r_mag        <= '0;
      r_prev_phase <= '0;
      r_prev_valid <= 1'b0;
    end else if (i_ce) begin
      r_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_phase      <= w_phase;
        r_dphase     <= w_dphase;
        r_increment  <= w_increment;
        r_mag        <= w_mag;
        r_prev_phase <= w_phase;
        r_prev_valid <= 1'b1;
      end
    end
  end

  assign o_phase     = r_phase;
  assign o_dphase    = r_dphase;
  assign o_increment = r_increment;
  assign o_magnitude = r_mag;

endmodule

// File: tb/tb_iq_freq_discriminator.sv
// Self-checking bench for iq_freq_discriminator: vector tables driven through a
// scoreboard, plus clock-enable toggling and mid-conversion reset sequences.
module tb_iq_freq_discriminator;

  localparam int PW = 12;
  localparam int IW = 17;
  localparam int AW = 32;
  localparam int SH = AW - 1 - PW;
`ifdef IQDISC_GAIN_COMP_EN
  localparam int  LAT      = PW + 3;
  localparam real MAG_GAIN = 1.0;
`else
  localparam int  LAT      = PW + 2;
  localparam real MAG_GAIN = 1.6468;
`endif

  logic                 i_clk = 1'b0;
  logic                 i_reset, i_ce, i_valid;
  logic signed [IW-1:0] i_sample_i, i_sample_q;
  logic                 o_ready, o_valid;
  logic        [PW-1:0] o_phase;
  logic signed [PW-1:0] o_dphase;
  logic        [AW-2:0] o_increment;
  logic          [IW:0] o_magnitude;

  iq_freq_discriminator #(.PW(PW), .IW(IW), .AW(AW)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_ce        (i_ce),
    .i_valid     (i_valid),
    .i_sample_i  (i_sample_i),
    .i_sample_q  (i_sample_q),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_phase     (o_phase),
    .o_dphase    (o_dphase),
    .o_increment (o_increment),
    .o_magnitude (o_magnitude)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int phase; int ph_tol;
    int dphase; int dp_tol;
    int mag; int mag_tol;
    int stamp;
  } exp_t;

  typedef struct {
    logic signed [IW-1:0] i;
    logic signed [IW-1:0] q;
    int                   phase;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0, n_pass = 0, en_cnt = 0, n_valid_seen = 0;
  bit   ce_toggle = 1'b0, model_first = 1'b1;
  int   model_prev = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int cdist(input int a, input int b);
    int d;
    d = (a - b) & 4095;
    return (d > 2048) ? 4096 - d : d;
  endfunction

  function automatic int wrap_s(input int d);
    int w;
    w = d & 4095;
    return (w >= 2048) ? w - 4096 : w;
  endfunction

  // Inputs change just after the falling edge; outputs are read 1-2 time units later.
  task automatic tick();
    @(negedge i_clk);
    if (ce_toggle) i_ce = ~i_ce;
    #1;
  endtask

  always @(posedge i_clk) if (i_ce && !i_reset) en_cnt++;

  always @(negedge i_clk) begin
    exp_t e;
    #2;
    if (o_valid) begin
      n_valid_seen++;
      check("valid_only_with_ce", i_ce == 1'b1, i_ce, 1);
      if (sb.size() == 0) begin
        check("unexpected_valid", 1'b0, 1, 0);
      end else begin
        e = sb.pop_front();
        if (e.ph_tol == 0) check("phase", o_phase == e.phase, o_phase, e.phase);
        else check("phase", cdist(int'(o_phase), e.phase) <= e.ph_tol, o_phase, e.phase);
        check("dphase", iabs(int'(o_dphase) - e.dphase) <= e.dp_tol, o_dphase, e.dphase);
        if (e.dphase - e.dp_tol >= 0)
          check("increment", (o_increment[SH-1:0] == '0) &&
                (iabs(int'(o_increment >> SH) - e.dphase) <= e.dp_tol),
                o_increment, longint'(e.dphase) << SH);
        else if (e.dphase + e.dp_tol < 0)
          check("increment_neg", o_increment == '0, o_increment, 0);
        check("magnitude", iabs(int'(o_magnitude) - e.mag) <= e.mag_tol, o_magnitude, e.mag);
        check("latency", en_cnt - e.stamp == LAT, en_cnt - e.stamp, LAT);
      end
    end
  end

  task automatic dds(input int ph, output logic signed [IW-1:0] si, output logic signed [IW-1:0] sq);
    real a;
    a  = 2.0 * 3.14159265358979 * real'(ph) / 4096.0;
    si = IW'(int'(32767.0 * $cos(a)));
    sq = IW'(int'(32767.0 * $sin(a)));
  endtask

  task automatic send(input logic signed [IW-1:0] si, input logic signed [IW-1:0] sq,
                      input int ph, input bit expect_res);
    int   n;
    exp_t e;
    real  m;
    i_sample_i = si;
    i_sample_q = sq;
    i_valid    = 1'b1;
    n = 0;
    while (!(o_ready && i_ce) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      check("accept_timeout", 1'b0, n, 500);
      i_valid = 1'b0;
      return;
    end
    if (expect_res) begin
      m         = $sqrt(real'(si) * real'(si) + real'(sq) * real'(sq)) * MAG_GAIN;
      e.phase   = ph;
      e.ph_tol  = (si == 0 && sq == 0) ? 0 : 2;
      e.dphase  = model_first ? 0 : wrap_s(ph - model_prev);
      e.dp_tol  = model_first ? 0 : 2;
      e.mag     = int'(m);
      e.mag_tol = (e.mag == 0) ? 0 : e.mag / 100 + 2;
      e.stamp   = en_cnt + 1;
      sb.push_back(e);
      model_prev  = ph;
      model_first = 1'b0;
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 2000) begin
      tick();
      n++;
    end
    check("drain", sb.size() == 0, sb.size(), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset     = 1'b0;
    model_first = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t                 axis [5];
    int                   seq [7];
    int                   seq_ce [3];
    logic signed [IW-1:0] si, sq;
    int                   v0;

    axis[0] = '{i: 17'sd32767,  q: 17'sd0,      phase: 0};
    axis[1] = '{i: 17'sd0,      q: 17'sd32767,  phase: 1024};
    axis[2] = '{i: -17'sd32768, q: 17'sd0,      phase: 2048};
    axis[3] = '{i: 17'sd0,      q: -17'sd32768, phase: 3072};
    axis[4] = '{i: 17'sd0,      q: 17'sd0,      phase: 0};
    seq     = '{0, 64, 128, 192, 4032, 64, 4032};
    seq_ce  = '{1000, 1100, 300};

    i_reset = 1'b1; i_ce = 1'b1; i_valid = 1'b0;
    i_sample_i = '0; i_sample_q = '0;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();

    check("reset_ready",     o_ready == 1'b1,      o_ready, 1);
    check("reset_valid",     o_valid == 1'b0,      o_valid, 0);
    check("reset_phase",     o_phase == '0,        o_phase, 0);
    check("reset_dphase",    o_dphase == '0,       o_dphase, 0);
    check("reset_increment", o_increment == '0,    o_increment, 0);
    check("reset_magnitude", o_magnitude == '0,    o_magnitude, 0);

    for (int k = 0; k < 5; k++) send(axis[k].i, axis[k].q, axis[k].phase, 1'b1);
    drain();

    do_reset();
    for (int k = 0; k < 7; k++) begin
      dds(seq[k], si, sq);
      send(si, sq, seq[k], 1'b1);
    end
    drain();

    ce_toggle = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dds(seq_ce[k], si, sq);
      send(si, sq, seq_ce[k], 1'b1);
    end
    drain();
    ce_toggle = 1'b0;
    i_ce      = 1'b1;
    tick();

    // Abort a conversion at iteration 5; nothing may come out of it.
    v0 = n_valid_seen;
    dds(512, si, sq);
    send(si, sq, 512, 1'b0);
    tick();
    repeat (5) tick();
    i_reset = 1'b1;
    repeat (3) tick();
    i_reset     = 1'b0;
    model_first = 1'b1;
    repeat (20) tick();
    check("abort_no_valid",  n_valid_seen == v0, n_valid_seen, v0);
    check("abort_ready",     o_ready == 1'b1,    o_ready, 1);
    check("abort_phase_clr", o_phase == '0,      o_phase, 0);

    dds(700, si, sq);
    send(si, sq, 700, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
